note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, 1000: CLK cycles per tempo tick; legal range 2..65535.
REQ-002 Parameter GAP_TICKS, 1: silent ticks inserted after every note; legal range 0..15.
REQ-003 Parameter LOOP, 1: 1 = restart from entry 0 at the end marker; 0 = stop at the end marker.
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 START  in  1  one-cycle pulse that begins playback from entry 0.
REQ-007 STOP  in  1  one-cycle pulse that aborts playback.
REQ-008 WR_EN  in  1  table write strobe.
REQ-009 WR_ADDR  in  4  table entry index.
REQ-010 WR_NOTE  in  8  note code to store; 0 = rest.
REQ-011 WR_DUR  in  4  duration in ticks; 0 = end-of-sequence marker.
REQ-012 NOTE  out  8  current note code, driven to the downstream DDS NOTE input.
REQ-013 GATE  out  1  high while a non-rest note sounds.
REQ-014 NOTE_STB  out  1  one-cycle pulse on every new NOTE load.
REQ-015 STEP  out  4  index of the current table entry.
REQ-016 BUSY  out  1  high in every state except IDLE.

Function
REQ-017 The table SHALL be 16 entries x {note[7:0], dur[3:0]}, register based, cleared to all zero by reset.
REQ-018 A write SHALL take effect at the clock edge where WR_EN=1 and BUSY=0; writes while BUSY=1 are ignored.
REQ-019 The FSM SHALL have states IDLE, LOAD, PLAY and GAP.
REQ-020 IDLE->LOAD on START=1 with STOP=0; STEP is cleared to 0 on that edge.
REQ-021 LOAD SHALL last exactly one cycle and read entry[STEP], including an entry written on the same edge as START.
REQ-022 LOAD with dur=0: if LOOP=1, STEP:=0 and remain in LOAD; if LOOP=0, go to IDLE with STEP:=0.
REQ-023 LOAD with dur!=0 SHALL go to PLAY and, on that edge, set NOTE:=note, GATE:=(note!=0) and counter:=dur.
REQ-024 NOTE_STB SHALL be high for exactly the first PLAY cycle of each note.
REQ-025 A tick prescaler SHALL count 0..TICK_DIV-1 and SHALL be cleared on entry to PLAY and on entry to GAP; a tick occurs when the count equals TICK_DIV-1.
REQ-026 PLAY SHALL last exactly dur*TICK_DIV cycles, then go to GAP with GATE:=0; if GAP_TICKS=0, it goes directly to LOAD with STEP+1.
REQ-027 GAP SHALL last GAP_TICKS*TICK_DIV cycles with GATE=0 and NOTE held, then go to LOAD with STEP:=STEP+1, wrapping 15->0.
REQ-028 The note period SHALL be 1+(dur+GAP_TICKS)*TICK_DIV cycles.
REQ-029 STOP=1 SHALL force IDLE from any state at the next edge, with GATE:=0, STEP:=0 and NOTE holding its last value.
REQ-030 STOP and START high in the same cycle: STOP wins.
REQ-031 START while BUSY=1 SHALL be ignored.
REQ-032 NOTE SHALL change only on a LOAD->PLAY edge.

Reset
REQ-033 RESET=1 SHALL immediately, without waiting for CLK, set state=IDLE, NOTE=0, GATE=0, NOTE_STB=0, STEP=0, BUSY=0, prescaler=0, counter=0 and all table entries=0.
REQ-034 RESET=1 during PLAY SHALL abort playback; after release, no output changes until the next START.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-035 Write {60,2},{0,1},{64,1},{0,0}, LOOP=0, pulse START -> the sequence SHALL be:
- 1 cycle after START: NOTE_STB=1, NOTE=60, GATE=1 for 8 cycles, then GATE=0 for 4 cycles;
- LOAD, then NOTE=0 with GATE=0 for 8 cycles;
- then NOTE=64 with GATE=1 for 4 cycles, GAP, LOAD of the end marker;
- BUSY=0 and STEP=0.
REQ-036 Same table with LOOP=1 -> after the end-marker LOAD, the next LOAD SHALL give NOTE=60 with NOTE_STB=1, with no IDLE cycle in between.
REQ-037 Empty table, START -> BUSY=1 for exactly 1 cycle, NOTE_STB never asserted, NOTE stays 0.
REQ-038 16 entries of {n,1}, LOOP=1 -> STEP SHALL go 15->0 and play entry 0 without passing an end marker.
REQ-039 During PLAY, START and STOP in the same cycle -> next cycle IDLE, GATE=0, NOTE unchanged; a WR_EN pulse while BUSY=1 leaves the table unchanged, checked by a later playback.
REQ-040 RESET asserted mid-note, between clock edges -> all outputs and table entries SHALL read 0 before the next CLK edge.

Source files
------------

// File: rtl/note_sequencer.sv
// Table-driven note sequencer: steps a 16-entry {note,dur} table and drives NOTE/GATE to a DDS.
// Latency: one LOAD cycle per entry, then dur*TICK_DIV PLAY cycles and GAP_TICKS*TICK_DIV GAP cycles.
// Backpressure: none; START is ignored while busy, STOP aborts at the next edge, table writes only when idle.
module note_sequencer #(
    parameter int TICK_DIV  = 1000,
    parameter int GAP_TICKS = 1,
    parameter int LOOP      = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       wr_en_i,
    input  logic [3:0] wr_addr_i,
    input  logic [7:0] wr_note_i,
    input  logic [3:0] wr_dur_i,
    output logic [7:0] note_o,
    output logic       gate_o,
    output logic       note_stb_o,
    output logic [3:0] step_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
    localparam logic [3:0]  GAP_CNT   = 4'(GAP_TICKS);

    state_t      state_q, state_d;
    logic [7:0]  note_q, note_d;
    logic        gate_q, gate_d;
    logic        stb_q, stb_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] presc_q, presc_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [7:0]  tbl_note_q [16];
    logic [3:0]  tbl_dur_q  [16];

    logic        busy;
    logic        tick;
    logic [7:0]  cur_note;
    logic [3:0]  cur_dur;

    assign busy     = (state_q != S_IDLE);
    assign tick     = (presc_q == PRESC_MAX);
    assign cur_note = tbl_note_q[step_q];
    assign cur_dur  = tbl_dur_q[step_q];

    // Table storage: writable only while idle so a running sequence never sees a torn entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                tbl_note_q[i] <= 8'd0;
                tbl_dur_q[i]  <= 4'd0;
            end
        end else if (wr_en_i && !busy) begin
            tbl_note_q[wr_addr_i] <= wr_note_i;
            tbl_dur_q[wr_addr_i]  <= wr_dur_i;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            note_q  <= 8'd0;
            gate_q  <= 1'b0;
            stb_q   <= 1'b0;
            step_q  <= 4'd0;
            presc_q <= 16'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            stb_q   <= stb_d;
            step_q  <= step_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: cnt_q counts remaining ticks of the current PLAY or GAP phase.
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        gate_d  = gate_q;
        stb_d   = 1'b0;
        step_d  = step_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    step_d  = 4'd0;
                end
            end
            S_LOAD: begin
                if (cur_dur == 4'd0) begin
                    // End marker: rewind, then either replay at once or park.
                    step_d  = 4'd0;
                    state_d = (LOOP != 0) ? S_LOAD : S_IDLE;
                end else begin
                    state_d = S_PLAY;
                    note_d  = cur_note;
                    gate_d  = (cur_note != 8'd0);
                    stb_d   = 1'b1;
                    cnt_d   = cur_dur;
                    presc_d = 16'd0;
                end
            end
            S_PLAY: begin
                presc_d = tick ? 16'd0 : presc_q + 16'd1;
                if (tick) begin
                    if (cnt_q == 4'd1) begin
                        gate_d = 1'b0;
                        if (GAP_TICKS == 0) begin
                            state_d = S_LOAD;
                            step_d  = step_q + 4'd1;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = GAP_CNT;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_GAP: begin
                presc_d = tick ? 16'd0 : presc_q + 16'd1;
                if (tick) begin
                    if (cnt_q == 4'd1) begin
                        state_d = S_LOAD;
                        step_d  = step_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // STOP overrides everything, including a simultaneous START; NOTE keeps its value.
        if (stop_i) begin
            state_d = S_IDLE;
            gate_d  = 1'b0;
            stb_d   = 1'b0;
            step_d  = 4'd0;
            presc_d = 16'd0;
            cnt_d   = 4'd0;
        end
    end

    assign note_o     = note_q;
    assign gate_o     = gate_q;
    assign note_stb_o = stb_q;
    assign step_o     = step_q;
    assign busy_o     = busy;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: one instance with LOOP=0, one with LOOP=1, shared stimulus.
// TICK_DIV=4, GAP_TICKS=1, so a note of dur d occupies 1 + (d+1)*4 cycles.
// Expected values are hand-derived cycle tables.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_note = 8'd0;
    logic [3:0] wr_dur = 4'd0;

    logic [7:0] note0, note1;
    logic       gate0, gate1, stb0, stb1, busy0, busy1;
    logic [3:0] step0, step1;

    int n_run  = 0;
    int n_fail = 0;

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .LOOP(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_note_i(wr_note), .wr_dur_i(wr_dur),
        .note_o(note0), .gate_o(gate0), .note_stb_o(stb0), .step_o(step0), .busy_o(busy0)
    );

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .LOOP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_note_i(wr_note), .wr_dur_i(wr_dur),
        .note_o(note1), .gate_o(gate1), .note_stb_o(stb1), .step_o(step1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    // Packed snapshot {busy, step, gate, stb, note}.
    logic [14:0] st0, st1;
    assign st0 = {busy0, step0, gate0, stb0, note0};
    assign st1 = {busy1, step1, gate1, stb1, note1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] n, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_note = n; wr_dur = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        cyc();
    endtask

    // Hand-derived trace of table {60,2},{0,1},{64,1},{0,0} with LOOP=0; k = cycles after START edge.
    function automatic logic [14:0] exp_seq(input int k);
        logic       b, g, s;
        logic [3:0] stp;
        logic [7:0] n;
        b   = (k <= 31);
        stp = (k <= 12) ? 4'd0 : (k <= 21) ? 4'd1 : (k <= 30) ? 4'd2 : (k == 31) ? 4'd3 : 4'd0;
        g   = ((k >= 1) && (k <= 8)) || ((k >= 23) && (k <= 26));
        s   = (k == 1) || (k == 14) || (k == 23);
        n   = (k == 0) ? 8'd0 : (k <= 13) ? 8'd60 : (k <= 22) ? 8'd0 : 8'd64;
        return {b, stp, g, s, n};
    endfunction

    initial begin
        int cnt;
        int seen;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state0", 32'(st0), 32'd0);
        chk("reset_state1", 32'(st1), 32'd0);

        // Basic sequence, then loop restart on the LOOP=1 instance.
        wr(4'd0, 8'd60, 4'd2);
        wr(4'd1, 8'd0,  4'd1);
        wr(4'd2, 8'd64, 4'd1);
        wr(4'd3, 8'd0,  4'd0);
        pulse_start();
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) cyc();
            chk($sformatf("seq_k%0d", k), 32'(st0), 32'(exp_seq(k)));
        end
        chk("loop_still_busy", 32'({busy1, step1}), 32'({1'b1, 4'd0}));
        cyc();
        chk("loop_restart", 32'({busy1, stb1, gate1, note1, step1}),
            32'({1'b1, 1'b1, 1'b1, 8'd60, 4'd0}));
        pulse_stop();
        chk("loop_stopped", 32'({busy1, gate1}), 32'd0);

        // Empty table: one LOAD cycle, no note.
        do_reset();
        pulse_start();
        chk("empty_busy_load", 32'(busy0), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("empty_idle_%0d", k), 32'({busy0, stb0, note0}), 32'd0);
        end
        pulse_stop();

        // START+STOP together during PLAY, and a write attempt while busy.
        do_reset();
        wr(4'd0, 8'd60, 4'd2);
        wr(4'd1, 8'd64, 4'd1);
        wr(4'd2, 8'd0,  4'd0);
        pulse_start();
        cyc();
        wr(4'd0, 8'd99, 4'd3);
        cyc();
        chk("play_before_stop", 32'({gate0, note0}), 32'({1'b1, 8'd60}));
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("startstop_idle0", 32'({busy0, gate0, step0, note0}), 32'({1'b0, 1'b0, 4'd0, 8'd60}));
        chk("startstop_idle1", 32'({busy1, gate1, step1, note1}), 32'({1'b0, 1'b0, 4'd0, 8'd60}));
        pulse_start();
        cyc();
        chk("busy_write_ignored", 32'({stb0, note0}), 32'({1'b1, 8'd60}));
        cnt = 0;
        while (gate0 && cnt < 50) begin
            cnt++;
            cyc();
        end
        chk("gate_len_dur2", 32'(cnt), 32'd8);

        // Asynchronous reset mid-note, checked before the next edge.
        pulse_stop();
        pulse_start();
        cyc();
        cyc();
        chk("pre_reset_playing", 32'({gate0, note0}), 32'({1'b1, 8'd60}));
        #2 rst = 1'b1;
        #1;
        chk("async_reset0", 32'(st0), 32'd0);
        chk("async_reset1", 32'(st1), 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("post_reset_quiet_%0d", k), 32'(st0), 32'd0);
        end
        pulse_start();
        chk("cleared_tbl_load", 32'(busy0), 32'd1);
        cyc();
        chk("cleared_tbl_idle", 32'({busy0, stb0, note0}), 32'd0);
        pulse_stop();

        // Sixteen one-tick notes: step wraps 15->0 with no end marker.
        do_reset();
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i + 1), 4'd1);
        pulse_start();
        seen = 0;
        for (int k = 0; k < 250 && seen < 17; k++) begin
            cyc();
            if (stb1) begin
                chk($sformatf("wrap_note_%0d", seen), 32'({step1, note1}),
                    32'({4'(seen % 16), 8'((seen % 16) + 1)}));
                seen++;
            end
        end
        chk("wrap_count", 32'(seen), 32'd17);
        pulse_stop();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
